sync_fifo: RTL

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_mem.sv | 27 ++
 rtl/sync_fifo.sv | 104 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO defaults, depth derivation and the status-flag bundle used by every FIFO variant.
// Declarations only: no logic, no latency, no flow control.
package fifo_pkg;

  localparam int DATASIZE_DEF  = 8;
  localparam int ADDRSIZE_DEF  = 4;
  localparam int AFULL_TH_DEF  = 14;
  localparam int AEMPTY_TH_DEF = 2;

  function automatic int depth_of(input int addrsize);
    return 1 << addrsize;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_mem.sv
// Dual-port FIFO storage: the write lands on the clock edge, the read is combinational from raddr.
// No reset and no flow control; the owner gates we and keeps raddr pointing at live data.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEF,
  parameter int ADDRSIZE = ADDRSIZE_DEF
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);

  localparam int DEPTH = depth_of(ADDRSIZE);

  logic [DATASIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO; registered read (data one cycle after the read edge) or first-word-fall-through.
// Writes while full and reads while empty are dropped and flagged by one-cycle overflow/underflow pulses.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATASIZE  = DATASIZE_DEF,
  parameter int ADDRSIZE  = ADDRSIZE_DEF,
  parameter int AFULL_TH  = AFULL_TH_DEF,
  parameter int AEMPTY_TH = AEMPTY_TH_DEF,
  parameter int FWFT      = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int PW = ADDRSIZE + 1;
  localparam int DEPTH = depth_of(ADDRSIZE);
  localparam logic [ADDRSIZE:0] DEPTH_C  = PW'(DEPTH);
  localparam logic [ADDRSIZE:0] AFULL_C  = PW'(AFULL_TH);
  localparam logic [ADDRSIZE:0] AEMPTY_C = PW'(AEMPTY_TH);
  localparam logic [ADDRSIZE:0] PTR_ONE  = PW'(1);

  logic [ADDRSIZE:0]   wptr;
  logic [ADDRSIZE:0]   rptr;
  logic [ADDRSIZE:0]   occ;
  fifo_flags_t         flags;
  logic                wr_acc;
  logic                rd_acc;
  logic [DATASIZE-1:0] mem_rdata;
  logic [DATASIZE-1:0] rdata_q;
  logic                overflow_q;
  logic                underflow_q;

  // Pointers carry an extra wrap bit, so the modular difference is the true occupancy.
  assign occ = wptr - rptr;

  always_comb begin
    flags              = '0;
    flags.full         = (occ == DEPTH_C);
    flags.empty        = (occ == '0);
    flags.almost_full  = (occ >= AFULL_C);
    flags.almost_empty = (occ <= AEMPTY_C);
  end

  // Acceptance uses the flags from before the edge, so a read never makes room for a same-cycle write.
  assign wr_acc = rst & winc & ~flags.full;
  assign rd_acc = rst & rinc & ~flags.empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr        <= '0;
      rptr        <= '0;
      rdata_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + PTR_ONE;
      if (rd_acc) begin
        rptr    <= rptr + PTR_ONE;
        rdata_q <= mem_rdata;
      end
      overflow_q  <= winc & flags.full;
      underflow_q <= rinc & flags.empty;
    end
  end

  fifo_mem #(
    .DATASIZE(DATASIZE),
    .ADDRSIZE(ADDRSIZE)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wptr[ADDRSIZE-1:0]),
    .wdata(wdata),
    .raddr(rptr[ADDRSIZE-1:0]),
    .rdata(mem_rdata)
  );

  // In fall-through mode the head word is shown directly; forced to zero while empty for determinism.
  always_comb begin
    rdata = rdata_q;
    if (FWFT != 0) rdata = flags.empty ? '0 : mem_rdata;
  end

  assign full         = flags.full;
  assign empty        = flags.empty;
  assign almost_full  = flags.almost_full;
  assign almost_empty = flags.almost_empty;
  assign count        = occ;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
